// File: rtl/sig_key_ctrl.sv
// Front-panel key controller: frequency index step/auto-repeat from UP/DOWN keys,
// waveform cycling from MODE, with a one-cycle strobe on any real config change.
module sig_key_ctrl #(
  parameter int IDX_W    = 8,
  parameter int IDX_MAX  = 199,
  parameter int HOLD_CYC = 25_000_000,
  parameter int RPT_CYC  = 5_000_000,
  parameter int CNT_W    = 25
) (
  input  logic             clk50m,
  input  logic             rst_n,
  input  logic             up_hi,
  input  logic             up_dbnc,
  input  logic             dn_hi,
  input  logic             dn_dbnc,
  input  logic             mode_hi,
  output logic [IDX_W-1:0] freq_idx,
  output logic [1:0]       wave_sel,
  output logic             cfg_upd,
  output logic             rpt_act
);

  typedef enum logic [1:0] {IDLE, HOLD, RPT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] RPT_LD  = CNT_W'(RPT_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(IDX_MAX);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             dir_q, dir_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [1:0]       wave_q, wave_d;
  logic             upd_q, upd_d;
  logic             rpt_q, rpt_d;

  logic             step_req;
  logic             step_dir;
  logic             sel_dbnc;

  assign sel_dbnc = dir_q ? dn_dbnc : up_dbnc;

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    dir_d    = dir_q;
    step_req = 1'b0;
    step_dir = dir_q;
    case (state_q)
      IDLE: begin
        // Simultaneous UP+DOWN is ambiguous, so it is dropped entirely.
        if (up_hi && !dn_hi) begin
          step_req = 1'b1;
          step_dir = 1'b0;
          dir_d    = 1'b0;
          timer_d  = HOLD_LD;
          state_d  = HOLD;
        end else if (dn_hi && !up_hi) begin
          step_req = 1'b1;
          step_dir = 1'b1;
          dir_d    = 1'b1;
          timer_d  = HOLD_LD;
          state_d  = HOLD;
        end
      end
      HOLD, RPT: begin
        // Release wins over an expiring timer: no step on the release cycle.
        if (!sel_dbnc) begin
          state_d = IDLE;
          timer_d = '0;
        end else if (timer_q != '0) begin
          timer_d = timer_q - 1'b1;
        end else begin
          step_req = 1'b1;
          timer_d  = RPT_LD;
          state_d  = RPT;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
      end
    endcase
  end

  always_comb begin
    idx_d = idx_q;
    if (step_req) begin
      if (!step_dir) idx_d = (idx_q == IDX_TOP) ? idx_q : idx_q + 1'b1;
      else           idx_d = (idx_q == '0)      ? idx_q : idx_q - 1'b1;
    end
    wave_d = mode_hi ? wave_q + 2'd1 : wave_q;
    upd_d  = (idx_d != idx_q) || (wave_d != wave_q);
    rpt_d  = (state_d == RPT);
  end

  always_ff @(posedge clk50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      timer_q <= '0;
      dir_q   <= 1'b0;
      idx_q   <= '0;
      wave_q  <= 2'd0;
      upd_q   <= 1'b0;
      rpt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      dir_q   <= dir_d;
      idx_q   <= idx_d;
      wave_q  <= wave_d;
      upd_q   <= upd_d;
      rpt_q   <= rpt_d;
    end
  end

  assign freq_idx = idx_q;
  assign wave_sel = wave_q;
  assign cfg_upd  = upd_q;
  assign rpt_act  = rpt_q;

endmodule

// File: tb/tb_sig_key_ctrl.sv
// Directed bench for sig_key_ctrl with short hold/repeat timing (HOLD 8, RPT 4, max index 5).
module tb_sig_key_ctrl;

  localparam int IDX_W = 8;

  logic             clk50m = 1'b0;
  logic             rst_n  = 1'b0;
  logic             up_hi = 1'b0, up_dbnc = 1'b0;
  logic             dn_hi = 1'b0, dn_dbnc = 1'b0;
  logic             mode_hi = 1'b0;
  logic [IDX_W-1:0] freq_idx;
  logic [1:0]       wave_sel;
  logic             cfg_upd;
  logic             rpt_act;

  int n_chk = 0;
  int n_err = 0;

  sig_key_ctrl #(
    .IDX_W(IDX_W), .IDX_MAX(5), .HOLD_CYC(8), .RPT_CYC(4), .CNT_W(4)
  ) dut (
    .clk50m(clk50m), .rst_n(rst_n),
    .up_hi(up_hi), .up_dbnc(up_dbnc),
    .dn_hi(dn_hi), .dn_dbnc(dn_dbnc),
    .mode_hi(mode_hi),
    .freq_idx(freq_idx), .wave_sel(wave_sel),
    .cfg_upd(cfg_upd), .rpt_act(rpt_act)
  );

  always #5 clk50m = ~clk50m;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs set before tick belong to the cycle ending at this edge; outputs are read 1 time unit later.
  task automatic tick();
    @(posedge clk50m);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    up_hi = 1'b0; up_dbnc = 1'b0; dn_hi = 1'b0; dn_dbnc = 1'b0; mode_hi = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_idx;
  logic exp_upd;

  initial begin
    // Reset state
    do_reset();
    chk("rst_idx", freq_idx, 0);
    chk("rst_wave", wave_sel, 0);
    chk("rst_upd", cfg_upd, 0);
    chk("rst_rpt", rpt_act, 0);

    // Short press: one step, no repeat
    up_hi = 1; up_dbnc = 1;
    tick();
    chk("t1_idx", freq_idx, 1);
    chk("t1_upd", cfg_upd, 1);
    up_hi = 0;
    tick();
    chk("t1_upd_clr", cfg_upd, 0);
    tick();
    up_dbnc = 0;
    repeat (14) tick();
    chk("t1_norpt_idx", freq_idx, 1);
    chk("t1_norpt_rpt", rpt_act, 0);

    // Held press: steps at +1, +9, +13, +17, +21, saturated afterwards
    do_reset();
    up_hi = 1; up_dbnc = 1;
    exp_idx = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      up_hi = 0;
      exp_upd = 1'b0;
      if (k == 1 || (k >= 9 && (k - 9) % 4 == 0)) begin
        if (exp_idx < 5) begin
          exp_idx++;
          exp_upd = 1'b1;
        end
      end
      chk($sformatf("t2_idx_k%0d", k), freq_idx, exp_idx);
      chk($sformatf("t2_upd_k%0d", k), cfg_upd, exp_upd);
      chk($sformatf("t2_rpt_k%0d", k), rpt_act, (k >= 9) ? 1 : 0);
    end
    up_dbnc = 0;
    tick();
    chk("t2_rel_rpt", rpt_act, 0);
    chk("t2_rel_idx", freq_idx, 5);

    // Down at 0: no change, but HOLD entered (repeat becomes active)
    do_reset();
    dn_hi = 1; dn_dbnc = 1;
    tick();
    dn_hi = 0;
    chk("t3_dn0_idx", freq_idx, 0);
    chk("t3_dn0_upd", cfg_upd, 0);
    repeat (8) tick();
    chk("t3_dn0_rpt", rpt_act, 1);
    chk("t3_dn0_rpt_upd", cfg_upd, 0);
    dn_dbnc = 0;
    tick();
    chk("t3_dn0_rel", rpt_act, 0);
    // Two quick up taps -> index 2, then both keys together
    repeat (2) begin
      up_hi = 1;
      tick();
      up_hi = 0;
      tick();
    end
    chk("t3_idx2", freq_idx, 2);
    up_hi = 1; dn_hi = 1; up_dbnc = 1; dn_dbnc = 1;
    tick();
    up_hi = 0; dn_hi = 0;
    chk("t3_both_idx", freq_idx, 2);
    chk("t3_both_upd", cfg_upd, 0);
    repeat (12) tick();
    chk("t3_both_rpt", rpt_act, 0);
    chk("t3_both_idx2", freq_idx, 2);
    up_dbnc = 0; dn_dbnc = 0;

    // Mode cycling with wrap
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      mode_hi = 1;
      tick();
      mode_hi = 0;
      chk($sformatf("t4_wave%0d", i), wave_sel, i % 4);
      chk($sformatf("t4_upd%0d", i), cfg_upd, 1);
      tick();
      chk($sformatf("t4_updclr%0d", i), cfg_upd, 0);
    end

    // Mode coincident with first auto step, then dn_hi ignored in RPT, release at timer 0
    do_reset();
    up_hi = 1; up_dbnc = 1;
    tick();
    up_hi = 0;
    chk("t5_idx1", freq_idx, 1);
    repeat (7) tick();
    chk("t5_pre_idx", freq_idx, 1);
    chk("t5_pre_rpt", rpt_act, 0);
    mode_hi = 1;
    tick();
    mode_hi = 0;
    chk("t5_co_idx", freq_idx, 2);
    chk("t5_co_wave", wave_sel, 1);
    chk("t5_co_upd", cfg_upd, 1);
    chk("t5_co_rpt", rpt_act, 1);
    dn_hi = 1;
    tick();
    dn_hi = 0;
    chk("t5_dn_upd", cfg_upd, 0);
    chk("t5_dn_idx", freq_idx, 2);
    tick();
    tick();
    chk("t5_dn_idx2", freq_idx, 2);
    tick();
    chk("t5_rpt_idx3", freq_idx, 3);
    chk("t5_rpt_upd", cfg_upd, 1);
    repeat (3) tick();
    up_dbnc = 0;
    tick();
    chk("t5_rel_idx", freq_idx, 3);
    chk("t5_rel_upd", cfg_upd, 0);
    chk("t5_rel_rpt", rpt_act, 0);

    // Async reset mid-RPT at idx 3, wave 2; held key afterwards must not step
    do_reset();
    repeat (2) begin
      mode_hi = 1;
      tick();
      mode_hi = 0;
    end
    up_hi = 1; up_dbnc = 1;
    tick();
    up_hi = 0;
    repeat (13) tick();
    chk("t6_pre_idx", freq_idx, 3);
    chk("t6_pre_wave", wave_sel, 2);
    chk("t6_pre_rpt", rpt_act, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_idx", freq_idx, 0);
    chk("t6_async_wave", wave_sel, 0);
    chk("t6_async_upd", cfg_upd, 0);
    chk("t6_async_rpt", rpt_act, 0);
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk($sformatf("t6_post_idx_k%0d", k), freq_idx, 0);
      chk($sformatf("t6_post_rpt_k%0d", k), rpt_act, 0);
    end
    up_dbnc = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
